// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: configurable width/parity/stop bits, oversampled RX with
// start-glitch rejection, per-word error flags and an RX FIFO with overrun pulse.
module uart_core_param #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ena,
  output logic                  tx_signal,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  rx_signal,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun
);

  localparam int unsigned SAMPLE_RATE = BAUD_RATE * OVERSAMPLE;
  localparam int unsigned DIV_RAW     = (CLK_FREQ + SAMPLE_RATE / 2) / SAMPLE_RATE;
  localparam int unsigned DIV         = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned BIT_CLKS    = DIV * OVERSAMPLE;
  localparam int unsigned BCW         = $clog2(BIT_CLKS);
  localparam int unsigned DVW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OSW         = $clog2(OVERSAMPLE);
  localparam int unsigned IDXW        = $clog2(DATA_WIDTH);
  localparam int unsigned PTRW        = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned CNTW        = PTRW + 1;
  localparam int unsigned ENTW        = DATA_WIDTH + 2;

  localparam logic [BCW-1:0]  BIT_LAST  = BCW'(BIT_CLKS - 1);
  localparam logic [DVW-1:0]  DIV_LAST  = DVW'(DIV - 1);
  localparam logic [OSW-1:0]  OS_HALF   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0]  OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DATA_WIDTH - 1);
  localparam logic [IDXW-1:0] STOP_LAST = IDXW'(STOP_BITS - 1);
  localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(RX_FIFO_DEPTH);
  localparam logic            PAR_ODD   = (PARITY == 1);
  localparam logic            HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  // ---------------------------------------------------------------- TX
  tx_state_e             tx_state_q, tx_state_d;
  logic [BCW-1:0]        tx_clk_q, tx_clk_d;
  logic [IDXW-1:0]       tx_idx_q, tx_idx_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_line_q, tx_line_d;
  logic                  tx_bit_end;

  assign tx_bit_end = (tx_clk_q == BIT_LAST);
  assign tx_ready   = (tx_state_q == TxIdle) & ena;
  assign tx_signal  = tx_line_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_clk_d   = tx_bit_end ? '0 : tx_clk_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    unique case (tx_state_q)
      TxIdle: begin
        tx_clk_d = '0;
        if (tx_valid && ena) begin
          tx_state_d = TxStart;
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_ODD;
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_idx_d   = '0;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_idx_q == IDX_LAST) begin
            tx_state_d = HAS_PAR ? TxParity : TxStop;
            tx_idx_d   = '0;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      TxParity: begin
        if (tx_bit_end) tx_state_d = TxStop;
      end
      TxStop: begin
        if (tx_bit_end) begin
          if (tx_idx_q == STOP_LAST) tx_state_d = TxIdle;
          else                       tx_idx_d   = tx_idx_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    // Line is registered from the next state so it changes on the same edge as the FSM.
    unique case (tx_state_d)
      TxStart:  tx_line_d = 1'b0;
      TxData:   tx_line_d = tx_shift_d[0];
      TxParity: tx_line_d = tx_par_d;
      default:  tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_q <= TxIdle;
      tx_clk_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_clk_q   <= tx_clk_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_e             rx_state_q, rx_state_d;
  logic                  rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic [DVW-1:0]        rx_div_q, rx_div_d;
  logic [OSW-1:0]        rx_os_q, rx_os_d;
  logic [IDXW-1:0]       rx_idx_q, rx_idx_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_ferr_q, rx_ferr_d;
  logic                  tick, os_hit, start_edge, push;

  assign tick       = (rx_div_q == DIV_LAST);
  assign start_edge = rx_prev_q & ~rx_sync2_q;
  // Start bit is checked at its centre; every later bit one full bit-time apart.
  assign os_hit     = tick && (rx_os_q == ((rx_state_q == RxStart) ? OS_HALF : OS_LAST));

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = tick ? '0 : rx_div_q + 1'b1;
    rx_os_d    = os_hit ? '0 : (tick ? rx_os_q + 1'b1 : rx_os_q);
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    push       = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_os_d = '0;
        if (ena && start_edge) begin
          rx_state_d = RxStart;
          rx_div_d   = '0;
        end
      end
      RxStart: begin
        if (os_hit) begin
          if (rx_sync2_q) begin
            rx_state_d = RxIdle;
          end else begin
            rx_state_d = RxData;
            rx_idx_d   = '0;
            rx_perr_d  = 1'b0;
            rx_ferr_d  = 1'b0;
          end
        end
      end
      RxData: begin
        if (os_hit) begin
          rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_WIDTH-1:1]};
          if (rx_idx_q == IDX_LAST) begin
            rx_state_d = HAS_PAR ? RxParity : RxStop;
            rx_idx_d   = '0;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RxParity: begin
        if (os_hit) begin
          rx_perr_d  = HAS_PAR & ((^rx_shift_q) ^ rx_sync2_q ^ PAR_ODD);
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (os_hit) begin
          rx_ferr_d = rx_ferr_q | ~rx_sync2_q;
          if (rx_idx_q == STOP_LAST) begin
            push       = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_q <= RxIdle;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_div_q   <= '0;
      rx_os_q    <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sync1_q <= rx_signal;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_div_q   <= rx_div_d;
      rx_os_q    <= rx_os_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [ENTW-1:0] mem_q [RX_FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            overrun_q;
  logic            full, pop, wr_en;
  logic [ENTW-1:0] head;

  assign full       = (count_q == FIFO_FULL);
  assign rx_valid   = (count_q != '0);
  assign pop        = rx_valid & rx_ready;
  assign wr_en      = push & (~full | pop);
  assign head       = mem_q[rd_ptr_q];
  assign rx_overrun = overrun_q;

  // Outputs are forced to zero while empty so the head reads as 0 out of reset.
  assign rx_data       = rx_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rx_frame_err  = rx_valid & head[DATA_WIDTH];
  assign rx_parity_err = rx_valid & head[DATA_WIDTH+1];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {rx_perr_q, rx_ferr_d, rx_shift_q};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overrun_q <= push & full & ~pop;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: 8E1, DIV=2, 16x oversampling, 32 clocks per bit.
module tb_uart_core_param;

  logic       clk = 1'b0;
  logic       reset_n, ena;
  logic       tx_signal, tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       rx_line, rx_drv, loopback;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_valid, rx_ready, rx_overrun;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int ovr_cnt = 0;

  always #5 clk = ~clk;

  assign rx_line = loopback ? tx_signal : rx_drv;

  uart_core_param #(
    .DATA_WIDTH   (8),
    .PARITY       (2),
    .STOP_BITS    (1),
    .CLK_FREQ     (3_200_000),
    .BAUD_RATE    (100_000),
    .OVERSAMPLE   (16),
    .RX_FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ena          (ena),
    .tx_signal    (tx_signal),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_signal    (rx_line),
    .rx_data      (rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun)
  );

  always @(negedge clk) begin
    if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_send(input logic [7:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_accept_in_time", 32'(n < 2000), 1);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic par_flip, input logic stop_val);
    logic [10:0] bits;
    bits = {stop_val, (^d) ^ par_flip, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      rx_drv = bits[b];
      repeat (32) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_rx();
    int n = 0;
    while (!rx_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("rx_valid_in_time", 32'(n < 600), 1);
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] d, input logic pe,
                          input logic fe);
    chk({tag, "_valid"}, rx_valid, 1);
    chk({tag, "_data"}, rx_data, d);
    chk({tag, "_perr"}, rx_parity_err, pe);
    chk({tag, "_ferr"}, rx_frame_err, fe);
  endtask

  initial begin
    logic [10:0] bits;
    int          low_cnt;
    int          base;

    reset_n  = 1'b0;
    ena      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    rx_drv   = 1'b1;
    loopback = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_signal", tx_signal, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
    chk("rst_rx_data", rx_data, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // TX 0xA5: 0,1,0,1,0,0,1,0,1, parity 0, stop 1
    tx_send(8'hA5);
    bits    = {1'b1, 1'b0, 8'hA5, 1'b0};
    low_cnt = 0;
    for (int i = 0; i < 352; i++) begin
      if (!tx_ready) low_cnt++;
      if ((i % 32) == 0 || (i % 32) == 31) chk("tx_a5_bit", tx_signal, bits[i/32]);
      @(negedge clk);
    end
    chk("tx_ready_low_cycles", low_cnt, 352);
    chk("tx_ready_back", tx_ready, 1);
    chk("tx_idle_line", tx_signal, 1);

    // Reset in the middle of a frame
    tx_send(8'h00);
    repeat (40) @(negedge clk);
    chk("midtx_line_low", tx_signal, 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midtx_reset_line", tx_signal, 1);
    chk("midtx_reset_ready", tx_ready, 1);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Loopback 0x3C then 0xFF
    loopback = 1'b1;
    tx_send(8'h3C);
    tx_send(8'hFF);
    wait_rx();
    chk_head("lb_3c", 8'h3C, 1'b0, 1'b0);
    pop_rx();
    wait_rx();
    chk_head("lb_ff", 8'hFF, 1'b0, 1'b0);
    pop_rx();
    chk("lb_empty", rx_valid, 0);
    repeat (400) @(negedge clk);
    loopback = 1'b0;
    repeat (4) @(negedge clk);

    // Parity flip on 0x01, low stop bit on 0x80
    drive_frame(8'h01, 1'b1, 1'b1);
    drive_frame(8'h80, 1'b0, 1'b0);
    repeat (32) @(negedge clk);
    chk_head("perr_01", 8'h01, 1'b1, 1'b0);
    pop_rx();
    chk_head("ferr_80", 8'h80, 1'b0, 1'b1);
    pop_rx();
    chk("err_empty", rx_valid, 0);

    // Overrun: five words into a four-entry FIFO
    base = ovr_cnt;
    for (int w = 0; w < 4; w++) drive_frame(8'(8'h10 + w), 1'b0, 1'b1);
    chk("ovr_none_yet", ovr_cnt - base, 0);
    drive_frame(8'h14, 1'b0, 1'b1);
    chk("ovr_one_pulse", ovr_cnt - base, 1);
    for (int w = 0; w < 4; w++) begin
      chk("drain_data", rx_data, 32'(8'h10 + w));
      chk("drain_valid", rx_valid, 1);
      pop_rx();
    end
    chk("drain_empty", rx_valid, 0);

    // 8-clock glitch is rejected
    rx_drv = 1'b0;
    repeat (8) @(negedge clk);
    rx_drv = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_no_word", rx_valid, 0);

    // ena low: no start detection and no TX accept
    ena = 1'b0;
    @(negedge clk);
    chk("ena_low_tx_ready", tx_ready, 0);
    drive_frame(8'h55, 1'b0, 1'b1);
    repeat (64) @(negedge clk);
    chk("ena_low_no_word", rx_valid, 0);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    drive_frame(8'h5A, 1'b0, 1'b1);
    chk_head("ena_back_5a", 8'h5A, 1'b0, 1'b0);
    pop_rx();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_core_param.md
# uart_core_param

Parametrised full-duplex UART core that is the successor to the fixed 8N1 `uart` used by the Tiny Tapeout top level. It adds:
- Configurable data width, parity and stop bits.
- 16x (configurable) oversampled receive with start-bit glitch rejection.
- Per-word parity/framing error reporting.
- An RX FIFO with overrun signalling.

It sits between the top-level pin mapping (`tx_signal` → `uio_out[0]`, `rx_signal` ← `uio_in[1]`) and user logic through valid/ready streams.

## Interface
Parameters:
- `DATA_WIDTH`, 8, payload bits per frame, legal range 5–9.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame, 1 or 2.
- `CLK_FREQ`, 50_000_000, clock frequency in Hz.
- `BAUD_RATE`, 115_200, line rate in bit/s.
- `OVERSAMPLE`, 16, RX samples per bit, even and ≥ 4.
- `RX_FIFO_DEPTH`, 4, RX FIFO entries, power of two ≥ 2.
- Derived: `DIV = round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE))`, must be ≥ 1; `BIT_CLKS = DIV*OVERSAMPLE`.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `ena` in 1: enable; when low, no new TX frame is accepted and no new RX start is detected. In-flight frames complete.
- `tx_signal` out 1: serial TX line, idle high.
- `tx_data` in `DATA_WIDTH`: word to transmit, sent LSB first.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: core can accept a word.
- `rx_signal` in 1: serial RX line, asynchronous.
- `rx_data` out `DATA_WIDTH`: word at the FIFO head.
- `rx_parity_err` out 1: parity mismatch on the head word; always 0 when `PARITY`=0.
- `rx_frame_err` out 1: a stop bit on the head word was sampled low.
- `rx_valid` out 1: FIFO not empty; `rx_data` and the two error flags are valid.
- `rx_ready` in 1: consumer pops the head word.
- `rx_overrun` out 1: one-cycle pulse when a completed word is dropped because the FIFO is full.

## Operation
- Reset values: `tx_signal`=1, `tx_ready`=1 (the value when `ena`=1), `rx_valid`=0, `rx_data`=0, error flags 0, `rx_overrun`=0. The FIFO is emptied, both FSMs go to IDLE and the RX synchroniser flops are preset to 1. Reset asserted mid-frame aborts the frame; `tx_signal` is 1 from the next edge.
- Frame format: start bit (0), then `DATA_WIDTH` data bits LSB first, then an optional parity bit, then `STOP_BITS` stop bits (1).
- Parity bit value:
  - Even: XOR of the data bits.
  - Odd: the inverse of that XOR.
- TX FSM, states IDLE → START → DATA → PARITY → STOP → IDLE:
  - PARITY is skipped when `PARITY`=0.
  - `tx_ready` = (state==IDLE) & `ena`.
  - A transfer occurs on `tx_valid & tx_ready`; `tx_data` is latched at that edge.
  - A private bit counter restarts on accept, so every bit lasts exactly `BIT_CLKS` clocks.
- RX front end: `rx_signal` passes through a 2-flop synchroniser. A sample tick occurs every `DIV` clocks; the tick counter is free-running in IDLE and restarts on start detection.
- RX FSM, states IDLE → START → DATA → PARITY → STOP → IDLE:
  - IDLE: a synchronised falling edge with `ena`=1 moves to START.
  - START: at tick `OVERSAMPLE/2` the line is re-sampled. If it is high, this is a glitch: return to IDLE and push nothing.
  - DATA, PARITY and STOP: each bit is sampled once at its centre, every `OVERSAMPLE` ticks after the start-bit centre.
  - Every stop bit is checked; any low stop bit sets the frame error for the word.
  - At the centre of the last stop bit, {data, parity_err, frame_err} is pushed and the FSM returns to IDLE immediately. A following start edge is therefore caught even with minimal stop time.
- RX FIFO: standard circular buffer with wrapping read/write pointers and a count.
  - Pop on `rx_valid & rx_ready`.
  - Push while full with no pop: the word is dropped, FIFO contents are unchanged, and `rx_overrun` pulses for 1 cycle.
  - Push and pop in the same cycle while full: both succeed and there is no overrun.
  - Push and pop in the same cycle while empty: the word is pushed; `rx_valid` rises the next cycle. There is no fall-through.

## Timing
- TX latency: accept at edge N gives `tx_signal`=0 from cycle N+1. The frame occupies `(1+DATA_WIDTH+(PARITY!=0)+STOP_BITS)*BIT_CLKS` cycles; `tx_ready` is high again in the cycle after the last stop bit ends.
- Back-to-back TX: re-asserting `tx_valid` lets the next start bit follow the previous stop bit with no extra idle cycle.
- RX latency: `rx_valid` rises 1 cycle after the push edge. The push edge is about 2 cycles (synchroniser) after the true mid-stop-bit point.
- Tolerated RX baud mismatch is at least ±2% at `OVERSAMPLE`=16.

## Test plan
All scenarios use `DATA_WIDTH`=8, `PARITY`=2, `STOP_BITS`=1, `CLK_FREQ`=3_200_000, `BAUD_RATE`=100_000, `OVERSAMPLE`=16 (giving `DIV`=2 and `BIT_CLKS`=32), and `RX_FIFO_DEPTH`=4.
- Reset: hold `reset_n`=0 for 3 clocks with `ena`=1 → `tx_signal`=1, `tx_ready`=1, `rx_valid`=0, `rx_overrun`=0. Assert reset mid-TX-frame → `tx_signal`=1 on the next cycle.
- TX 0xA5 → line carries 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each bit exactly 32 clocks; `tx_ready` is low for 352 cycles.
- Loopback (`tx_signal`→`rx_signal`) of 0x3C then 0xFF back-to-back → `rx_data` 0x3C then 0xFF, both error flags 0.
- Inject a parity-bit flip on 0x01, then a low stop bit on 0x80 → first word has `rx_parity_err`=1, second has `rx_frame_err`=1, and both data values are correct.
- Hold `rx_ready`=0 and send 0x10–0x14 → one `rx_overrun` pulse on the 5th word; draining then yields 0x10–0x13 in order.
- Drive an 8-clock low glitch on `rx_signal`, and separately send a frame with `ena`=0 → `rx_valid` stays 0 in both cases.
